ps2_frame_sequencer: RTL and testbench

Receive controller for the PS/2 keyboard path. Synchronises the raw PS/2 clock and data lines and walks each 11-bit frame (start, 8 data LSB-first, odd parity, stop) through a state machine. Delivers the assembled scan code with one-cycle parity and strobe qualifiers to the downstream data output register, which latches only when both are high. Aborts stalled frames with a watchdog.

---
 rtl/ps2_frame_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_frame_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_sequencer.sv
// PS/2 receive sequencer: synchronises the raw lines, frames 11-bit words, and emits scan code + qualifier pulses.
// Optional E0/F0 prefix folding is enabled by defining PS2_PREFIX_DECODE_EN.
module ps2_frame_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       control_clock,
  input  logic       control_reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] scan_code_for_buffering,
  output logic       parity_detected,
  output logic       strobe_detected,
  output logic       frame_error,
  output logic       busy,
  output logic       extended_key,
  output logic       key_released
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [1:0]             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_ok_q, parity_ok_d;
  logic                   stop_q, stop_d;
  logic                   fin_q, fin_d;
  logic [CNT_W-1:0]       wdog_q, wdog_d;
  logic [7:0]             scan_q, scan_d;
  logic                   par_det_q, par_det_d;
  logic                   stb_det_q, stb_det_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;

  logic                   fall_c;
  logic                   data_c;
  logic                   frame_ok_c;

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_flag_q, ext_flag_d;
  logic rel_flag_q, rel_flag_d;
  logic ext_key_q, ext_key_d;
  logic rel_key_q, rel_key_d;
`endif

  assign fall_c     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign data_c     = data_sync_q[SYNC_STAGES-1];
  assign frame_ok_c = parity_ok_q & stop_q;

  // Next-state, watchdog and delivery logic
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    stop_d      = stop_q;
    fin_d       = 1'b0;
    wdog_d      = wdog_q;
    scan_d      = scan_q;
    par_det_d   = 1'b0;
    stb_det_d   = 1'b0;
    ferr_d      = 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
    ext_flag_d  = ext_flag_q;
    rel_flag_d  = rel_flag_q;
    ext_key_d   = ext_key_q;
    rel_key_d   = rel_key_q;
`endif

    // A falling edge always beats a simultaneous expiry
    if ((state_q == ST_IDLE) || fall_c) begin
      wdog_d = '0;
    end else if (wdog_q == WDOG_LAST) begin
      wdog_d  = '0;
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
      ext_flag_d = 1'b0;
      rel_flag_d = 1'b0;
`endif
    end else begin
      wdog_d = wdog_q + CNT_W'(1);
    end

    if (fall_c) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_c) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d = {data_c, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_ok_d = ^{shift_q, data_c};
          state_d     = ST_STOP;
        end
        default: begin
          stop_d  = data_c;
          fin_d   = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end

    // Completed frame is presented one cycle after the stop edge
    if (fin_q) begin
`ifdef PS2_PREFIX_DECODE_EN
      if (frame_ok_c && (shift_q == 8'hE0)) begin
        ext_flag_d = 1'b1;
      end else if (frame_ok_c && (shift_q == 8'hF0)) begin
        rel_flag_d = 1'b1;
      end else begin
        scan_d     = shift_q;
        par_det_d  = parity_ok_q;
        stb_det_d  = stop_q;
        ferr_d     = ~frame_ok_c;
        ext_key_d  = frame_ok_c & ext_flag_q;
        rel_key_d  = frame_ok_c & rel_flag_q;
        ext_flag_d = 1'b0;
        rel_flag_d = 1'b0;
      end
`else
      scan_d    = shift_q;
      par_det_d = parity_ok_q;
      stb_det_d = stop_q;
      ferr_d    = ~frame_ok_c;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; synchronisers reset to the idle-high line level
  always_ff @(posedge control_clock or posedge control_reset) begin
    if (control_reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      parity_ok_q <= 1'b0;
      stop_q      <= 1'b0;
      fin_q       <= 1'b0;
      wdog_q      <= '0;
      scan_q      <= 8'd0;
      par_det_q   <= 1'b0;
      stb_det_q   <= 1'b0;
      ferr_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
      ext_flag_q  <= 1'b0;
      rel_flag_q  <= 1'b0;
      ext_key_q   <= 1'b0;
      rel_key_q   <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_ok_q <= parity_ok_d;
      stop_q      <= stop_d;
      fin_q       <= fin_d;
      wdog_q      <= wdog_d;
      scan_q      <= scan_d;
      par_det_q   <= par_det_d;
      stb_det_q   <= stb_det_d;
      ferr_q      <= ferr_d;
      busy_q      <= busy_d;
`ifdef PS2_PREFIX_DECODE_EN
      ext_flag_q  <= ext_flag_d;
      rel_flag_q  <= rel_flag_d;
      ext_key_q   <= ext_key_d;
      rel_key_q   <= rel_key_d;
`endif
    end
  end

  assign scan_code_for_buffering = scan_q;
  assign parity_detected         = par_det_q;
  assign strobe_detected         = stb_det_q;
  assign frame_error             = ferr_q;
  assign busy                    = busy_q;
`ifdef PS2_PREFIX_DECODE_EN
  assign extended_key            = ext_key_q;
  assign key_released            = rel_key_q;
`else
  assign extended_key            = 1'b0;
  assign key_released            = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_frame_sequencer.sv
// Self-checking bench for ps2_frame_sequencer: directed frames plus random frames against a frame-level model.
module tb_ps2_frame_sequencer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TOUT = 300;
  localparam int unsigned HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] scan;
  logic       par, stb, err, busy, ext, rel;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;

  typedef struct {
    logic [7:0] code;
    logic       par;
    logic       stb;
    logic       err;
    logic       ext;
    logic       rel;
    int         cyc;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  logic [7:0] m_scan = 8'd0;
  logic       m_fext = 1'b0, m_frel = 1'b0, m_oext = 1'b0, m_orel = 1'b0;

  ps2_frame_sequencer #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TOUT),
    .CNT_W         (16)
  ) dut (
    .control_clock          (clk),
    .control_reset          (rst),
    .ps2_clk_in             (ps2_clk),
    .ps2_data_in            (ps2_dat),
    .scan_code_for_buffering(scan),
    .parity_detected        (par),
    .strobe_detected        (stb),
    .frame_error            (err),
    .busy                   (busy),
    .extended_key           (ext),
    .key_released           (rel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with any qualifier high is logged as one event
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst && (stb || par || err)) begin
      e.code = scan; e.par = par; e.stb = stb; e.err = err;
      e.ext = ext; e.rel = rel; e.cyc = cyc;
      got_q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
    logic pok, v;
    ev_t e;
    pok = ^{d, p};
    v = pok & s;
`ifdef PS2_PREFIX_DECODE_EN
    if (v && d == 8'hE0) begin m_fext = 1'b1; return; end
    if (v && d == 8'hF0) begin m_frel = 1'b1; return; end
    m_oext = v & m_fext;
    m_orel = v & m_frel;
    m_fext = 1'b0;
    m_frel = 1'b0;
`endif
    m_scan = d;
    e.code = d; e.par = pok; e.stb = s; e.err = ~v;
    e.ext = m_oext; e.rel = m_orel; e.cyc = last_fall + int'(SYNC) + 2;
    exp_q.push_back(e);
  endtask

  task automatic model_timeout();
    ev_t e;
    m_fext = 1'b0;
    m_frel = 1'b0;
    e.code = m_scan; e.par = 1'b0; e.stb = 1'b0; e.err = 1'b1;
    e.ext = m_oext; e.rel = m_orel; e.cyc = -1;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(s);
    @(negedge clk);
    ps2_dat = 1'b1;
    model_frame(d, p, s);
  endtask

  task automatic drain(input string tag);
    ev_t g, x;
    int lat;
    repeat (20) @(negedge clk);
    check($sformatf("%s.count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      check($sformatf("%s.code", tag), 32'(g.code), 32'(x.code));
      check($sformatf("%s.parity", tag), 32'(g.par), 32'(x.par));
      check($sformatf("%s.strobe", tag), 32'(g.stb), 32'(x.stb));
      check($sformatf("%s.error", tag), 32'(g.err), 32'(x.err));
      check($sformatf("%s.ext", tag), 32'(g.ext), 32'(x.ext));
      check($sformatf("%s.rel", tag), 32'(g.rel), 32'(x.rel));
      lat = g.cyc - last_fall;
      if (x.cyc >= 0)
        check($sformatf("%s.latency", tag), 32'(g.cyc), 32'(x.cyc));
      else
        check($sformatf("%s.tmo_window", tag),
              32'((lat >= int'(TOUT)) && (lat <= int'(TOUT + SYNC) + 4)), 32'd1);
    end
    got_q.delete();
    exp_q.delete();
    check($sformatf("%s.busy_idle", tag), 32'(busy), 32'd0);
    check($sformatf("%s.scan_hold", tag), 32'(scan), 32'(m_scan));
    check($sformatf("%s.ext_hold", tag), 32'(ext), 32'(m_oext));
    check($sformatf("%s.rel_hold", tag), 32'(rel), 32'(m_orel));
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s;
    int         r;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.scan", 32'(scan), 32'd0);
    check("rst.quals", 32'({par, stb, err, busy, ext, rel}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("good_1c");

    // Bad parity
    send_frame(8'h1C, 1'b1, 1'b1);
    drain("badpar_1c");

    // Bad stop, good parity
    send_frame(8'h5A, 1'b1, 1'b0);
    drain("badstop_5a");

    // Stalled frame: start + 4 data bits, then silence
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (4) @(negedge clk);
    check("stall.busy", 32'(busy), 32'd1);
    repeat (TOUT + 40) @(negedge clk);
    model_timeout();
    drain("timeout");
    send_frame(8'h29, ~(^8'h29), 1'b1);
    drain("after_tmo_29");

    // Asynchronous reset mid-frame
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    #3 rst = 1'b1;
    @(negedge clk);
    check("midrst.scan", 32'(scan), 32'd0);
    check("midrst.quals", 32'({par, stb, err, busy, ext, rel}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_scan = 8'd0; m_fext = 1'b0; m_frel = 1'b0; m_oext = 1'b0; m_orel = 1'b0;
    check("midrst.no_events", 32'(got_q.size()), 32'd0);
    got_q.delete();
    repeat (3) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("post_rst_1c");

    // Prefix sequence
    send_frame(8'hE0, ~(^8'hE0), 1'b1);
    send_frame(8'hF0, ~(^8'hF0), 1'b1);
    send_frame(8'h75, ~(^8'h75), 1'b1);
    drain("prefix_75");
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("prefix_after_1c");

    // Random frames, including prefixes and corrupted parity/stop
    for (int n = 0; n < 16; n++) begin
      r = int'($urandom_range(0, 7));
      d = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      p = ~(^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s);
      drain($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

endmodule
